// File: rtl/pc_ir_stage.sv
// pc_ir_stage: multicycle MIPS fetch-side registers (PC, IR, MDR, ALUOut) with IR field decode.
module pc_ir_stage #(
    parameter int BIT_WIDTH = 32,
    parameter int BIT_CTRL = 6,
    parameter logic [BIT_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PCWrite,
    input  logic                 Branch,
    input  logic                 Zero,
    input  logic                 PCSrc,
    input  logic                 IorD,
    input  logic                 IRWrite,
    input  logic [BIT_WIDTH-1:0] ALUResult,
    input  logic [BIT_WIDTH-1:0] MemRdData,
    output logic [BIT_WIDTH-1:0] MemAddr,
    output logic [BIT_WIDTH-1:0] PC,
    output logic                 PCEn,
    output logic [BIT_WIDTH-1:0] Instr,
    output logic [BIT_CTRL-1:0]  Op,
    output logic [BIT_CTRL-1:0]  Funct,
    output logic [4:0]           Rs,
    output logic [4:0]           Rt,
    output logic [4:0]           Rd,
    output logic [BIT_WIDTH-1:0] SignImm,
    output logic [BIT_WIDTH-1:0] Data,
    output logic [BIT_WIDTH-1:0] ALUOut,
    output logic                 MisalignErr
);
    logic [BIT_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, data_q, aluout_q, pc_next;
    logic                 misalign_q, misalign_d;

    // The PC is always stored word aligned; a misaligned target is flagged, not trapped.
    always_comb begin
        PCEn       = PCWrite | (Branch & Zero);
        pc_next    = PCSrc ? aluout_q : ALUResult;
        pc_d       = PCEn ? {pc_next[BIT_WIDTH-1:2], 2'b00} : pc_q;
        misalign_d = misalign_q | (PCEn & |pc_next[1:0]);
        instr_d    = IRWrite ? MemRdData : instr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            data_q     <= '0;
            aluout_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            data_q     <= MemRdData;
            aluout_q   <= ALUResult;
            misalign_q <= misalign_d;
        end
    end

    assign MemAddr     = IorD ? aluout_q : pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Op          = instr_q[BIT_WIDTH-1 -: BIT_CTRL];
    assign Funct       = instr_q[BIT_CTRL-1:0];
    assign Rs          = instr_q[25:21];
    assign Rt          = instr_q[20:16];
    assign Rd          = instr_q[15:11];
    assign SignImm     = {{(BIT_WIDTH-16){instr_q[15]}}, instr_q[15:0]};
    assign Data        = data_q;
    assign ALUOut      = aluout_q;
    assign MisalignErr = misalign_q;
endmodule

// File: tb/tb_pc_ir_stage.sv
// tb_pc_ir_stage: directed vectors for pc_ir_stage; expectations queued by stimulus, checked by a negedge monitor.
module tb_pc_ir_stage;
    logic        clk = 1'b0;
    logic        rst, PCWrite, Branch, Zero, PCSrc, IorD, IRWrite;
    logic [31:0] ALUResult, MemRdData, MemAddr, PC, Instr, SignImm, Data, ALUOut;
    logic [5:0]  Op, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic        PCEn, MisalignErr;

    typedef enum int {S_PC, S_INSTR, S_OP, S_FUNCT, S_RS, S_RT, S_RD, S_IMM, S_DATA,
                      S_ALUOUT, S_ADDR, S_PCEN, S_MIS} sig_e;
    typedef struct {sig_e s; logic [31:0] v;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    pc_ir_stage dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero), .PCSrc(PCSrc),
        .IorD(IorD), .IRWrite(IRWrite), .ALUResult(ALUResult), .MemRdData(MemRdData),
        .MemAddr(MemAddr), .PC(PC), .PCEn(PCEn), .Instr(Instr), .Op(Op), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .SignImm(SignImm), .Data(Data), .ALUOut(ALUOut),
        .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            S_PC:     return PC;
            S_INSTR:  return Instr;
            S_OP:     return {26'd0, Op};
            S_FUNCT:  return {26'd0, Funct};
            S_RS:     return {27'd0, Rs};
            S_RT:     return {27'd0, Rt};
            S_RD:     return {27'd0, Rd};
            S_IMM:    return SignImm;
            S_DATA:   return Data;
            S_ALUOUT: return ALUOut;
            S_ADDR:   return MemAddr;
            S_PCEN:   return {31'd0, PCEn};
            default:  return {31'd0, MisalignErr};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.s);
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL %s at %0t: got %h expected %h", e.s.name(), $time, a, e.v);
            end
        end
    end

    task automatic expect_v(sig_e s, logic [31:0] v);
        q.push_back('{s, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {rst, PCWrite, Branch, Zero, PCSrc, IorD, IRWrite} = 7'b1000000;
        ALUResult = 0;
        MemRdData = 0;
        step(); step();
        // reset state, then fetch
        rst = 0; IRWrite = 1; PCWrite = 1; ALUResult = 32'h0040_0004; MemRdData = 32'h0123_4020;
        expect_v(S_PC, 32'h0040_0000); expect_v(S_INSTR, 0); expect_v(S_OP, 0); expect_v(S_IMM, 0);
        expect_v(S_DATA, 0); expect_v(S_ALUOUT, 0); expect_v(S_MIS, 0);
        expect_v(S_ADDR, 32'h0040_0000); expect_v(S_PCEN, 1);
        step();
        IRWrite = 0; PCWrite = 0; ALUResult = 32'h0040_0100; MemRdData = 0;
        expect_v(S_PC, 32'h0040_0004); expect_v(S_INSTR, 32'h0123_4020); expect_v(S_OP, 0);
        expect_v(S_FUNCT, 6'h20); expect_v(S_RS, 9); expect_v(S_RT, 3); expect_v(S_RD, 8);
        expect_v(S_ALUOUT, 32'h0040_0004); expect_v(S_DATA, 32'h0123_4020);
        step();
        // branch not taken then taken, target from ALUOut
        Branch = 1; PCSrc = 1; Zero = 0;
        expect_v(S_PCEN, 0); expect_v(S_ALUOUT, 32'h0040_0100);
        step();
        Zero = 1;
        expect_v(S_PC, 32'h0040_0004); expect_v(S_PCEN, 1);
        step();
        Branch = 0; Zero = 0; PCSrc = 0; ALUResult = 32'h1000_0008;
        expect_v(S_PC, 32'h0040_0100);
        step();
        // load path
        IorD = 1; MemRdData = 32'hDEAD_BEEF;
        expect_v(S_ADDR, 32'h1000_0008);
        step();
        IorD = 0; MemRdData = 0;
        PCWrite = 1; Branch = 1; Zero = 0; ALUResult = 32'h0040_0200;
        expect_v(S_DATA, 32'hDEAD_BEEF); expect_v(S_PCEN, 1);
        step();
        PCWrite = 0; Branch = 0;
        expect_v(S_PC, 32'h0040_0200);
        // sign extension
        IRWrite = 1; MemRdData = 32'h8C43_FFFC;
        step();
        MemRdData = 32'h2042_7FFF;
        expect_v(S_IMM, 32'hFFFF_FFFC); expect_v(S_OP, 6'h23); expect_v(S_RS, 2); expect_v(S_RT, 3);
        step();
        IRWrite = 0; MemRdData = 32'h1111_1111;
        expect_v(S_IMM, 32'h0000_7FFF); expect_v(S_OP, 6'h08);
        step();
        expect_v(S_INSTR, 32'h2042_7FFF);
        // wrap-around
        PCWrite = 1; ALUResult = 32'hFFFF_FFFC;
        step();
        ALUResult = 0;
        expect_v(S_PC, 32'hFFFF_FFFC);
        step();
        ALUResult = 32'h0040_0006;
        expect_v(S_PC, 0); expect_v(S_MIS, 0);
        step();
        // misalignment is sticky
        ALUResult = 32'h0040_0008;
        expect_v(S_PC, 32'h0040_0004); expect_v(S_MIS, 1);
        step();
        PCWrite = 0;
        expect_v(S_PC, 32'h0040_0008); expect_v(S_MIS, 1);
        step();
        // reset wins over simultaneous strobes
        rst = 1; IRWrite = 1; PCWrite = 1; ALUResult = 32'h1234_5678; MemRdData = 32'hCAFE_F00D;
        step();
        rst = 0; IRWrite = 0; PCWrite = 0; ALUResult = 0; MemRdData = 0;
        expect_v(S_PC, 32'h0040_0000); expect_v(S_INSTR, 0); expect_v(S_ALUOUT, 0);
        expect_v(S_DATA, 0); expect_v(S_MIS, 0);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
